// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: FSM encoding and slice width.
package nibble_serial_adder_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_serial_adder_fa4.sv
// Structural 4-bit ripple-carry adder built from per-bit full-adder equations.
module FA_4bit_st (
  output logic [3:0] s,
  output logic       cout,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin
);

  logic [4:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < 4; i++) begin : g_bit
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// Wide adder that streams operands through one 4-bit adder, LS nibble first,
// with a registered carry between nibble cycles and valid/ready on both sides.
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NIB_W*NIBBLES-1:0] a,
  input  logic [NIB_W*NIBBLES-1:0] b,
  input  logic                    cin,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NIB_W*NIBBLES-1:0] sum,
  output logic                    cout
);

  localparam int W     = NIB_W * NIBBLES;
  localparam int CNT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  state_t           state, state_nxt;
  logic [W-1:0]     a_sh, b_sh, sum_sh, sum_nxt;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic [NIB_W-1:0] s_nib;
  logic             c_nib;
  logic             accept, last;

  FA_4bit_st u_fa (
    .s   (s_nib),
    .cout(c_nib),
    .a   (a_sh[NIB_W-1:0]),
    .b   (b_sh[NIB_W-1:0]),
    .cin (carry)
  );

  // New nibble enters the sum register from the top so it ends up LS-aligned.
  if (NIBBLES == 1) begin : g_one
    assign sum_nxt = s_nib;
  end else begin : g_multi
    assign sum_nxt = {s_nib, sum_sh[W-1:NIB_W]};
  end

  assign last      = (cnt == CNT_W'(NIBBLES - 1));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign sum       = sum_sh;
  assign cout      = carry;

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        // Consuming edge may also accept the next operands.
        in_ready = out_ready;
        if (out_ready) state_nxt = in_valid ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      carry  <= 1'b0;
      sum_sh <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        carry <= cin;
        cnt   <= '0;
      end else if (state == RUN) begin
        sum_sh <= sum_nxt;
        carry  <= c_nib;
        cnt    <= cnt + 1'b1;
      end
    end
  end

  // Operand shift registers carry no state worth resetting.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_sh <= a;
      b_sh <= b;
    end else if (state == RUN) begin
      a_sh <= a_sh >> NIB_W;
      b_sh <= b_sh >> NIB_W;
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed-vector bench for nibble_serial_adder at NIBBLES=4 and NIBBLES=1.
module tb_nibble_serial_adder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        iv, ir, ci, ov, ordy, co;
  logic [15:0] a, b, s;
  logic        iv1, ir1, ci1, ov1, ordy1, co1;
  logic [3:0]  a1, b1, s1;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc;

  nibble_serial_adder #(.NIBBLES(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir), .a(a), .b(b), .cin(ci),
    .out_valid(ov), .out_ready(ordy), .sum(s), .cout(co)
  );

  nibble_serial_adder #(.NIBBLES(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1), .cin(ci1),
    .out_valid(ov1), .out_ready(ordy1), .sum(s1), .cout(co1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_out4(output int c);
    c = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      c++;
      if (ov) break;
    end
  endtask

  // Starts from IDLE, one cycle past a rising edge, with ordy=1.
  task automatic op4(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                     input logic tc, input logic [15:0] es, input logic ec);
    int c;
    chk({tag, "_in_ready"}, ir, 1);
    a = ta; b = tb; ci = tc; iv = 1'b1;
    @(posedge clk); #1;
    iv = 1'b0; a = '0; b = '0; ci = 1'b0;
    wait_out4(c);
    chk({tag, "_latency"}, c, 4);
    chk({tag, "_sum"}, s, es);
    chk({tag, "_cout"}, co, ec);
    @(posedge clk); #1;
    chk({tag, "_consumed"}, ov, 0);
  endtask

  task automatic op1(input string tag, input logic [3:0] ta, input logic [3:0] tb,
                     input logic tc, input logic [3:0] es, input logic ec);
    int c;
    a1 = ta; b1 = tb; ci1 = tc; iv1 = 1'b1;
    @(posedge clk); #1;
    iv1 = 1'b0;
    c = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      c++;
      if (ov1) break;
    end
    chk({tag, "_latency"}, c, 1);
    chk({tag, "_sum"}, s1, es);
    chk({tag, "_cout"}, co1, ec);
    @(posedge clk); #1;
    chk({tag, "_consumed"}, ov1, 0);
  endtask

  initial begin
    rst = 1'b1;
    iv = 1'b0; a = '0; b = '0; ci = 1'b0; ordy = 1'b1;
    iv1 = 1'b0; a1 = '0; b1 = '0; ci1 = 1'b0; ordy1 = 1'b1;
    #2;
    chk("rst_in_ready", ir, 1);
    chk("rst_out_valid", ov, 0);
    chk("rst_sum", s, 0);
    chk("rst_cout", co, 0);
    #10 rst = 1'b0;
    @(posedge clk); #1;

    op4("add_basic", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);
    op4("ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
    op4("all_ones", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);

    // Backpressure: hold result, ignore operands offered while stalled.
    ordy = 1'b0;
    a = 16'h0009; b = 16'h000E; ci = 1'b0; iv = 1'b1;
    @(posedge clk); #1;
    iv = 1'b0;
    wait_out4(cyc);
    chk("bp_latency", cyc, 4);
    for (int i = 0; i < 6; i++) begin
      chk("bp_sum", s, 16'h0017);
      chk("bp_cout", co, 0);
      chk("bp_out_valid", ov, 1);
      chk("bp_in_ready", ir, 0);
      if (i == 2) begin
        a = 16'h0505; b = 16'h0505; iv = 1'b1;
      end
      @(posedge clk); #1;
      iv = 1'b0;
    end
    ordy = 1'b1;
    @(posedge clk); #1;
    chk("bp_released", ov, 0);
    chk("bp_idle_ready", ir, 1);
    for (int i = 0; i < 6; i++) begin
      chk("bp_no_extra", ov, 0);
      @(posedge clk); #1;
    end

    // Back-to-back: second pair taken on the consuming edge.
    a = 16'h0001; b = 16'h0001; ci = 1'b0; iv = 1'b1;
    @(posedge clk); #1;
    a = 16'h8000; b = 16'h8000;
    wait_out4(cyc);
    chk("b2b1_latency", cyc, 4);
    chk("b2b1_sum", s, 16'h0002);
    chk("b2b1_cout", co, 0);
    chk("b2b1_in_ready", ir, 1);
    @(posedge clk); #1;
    iv = 1'b0;
    chk("b2b_running", ov, 0);
    chk("b2b_busy", ir, 0);
    wait_out4(cyc);
    chk("b2b2_latency", cyc, 4);
    chk("b2b2_sum", s, 16'h0000);
    chk("b2b2_cout", co, 1);
    @(posedge clk); #1;
    chk("b2b_idle", ir, 1);

    // Reset two cycles into RUN.
    a = 16'hFFFF; b = 16'hFFFF; ci = 1'b1; iv = 1'b1;
    @(posedge clk); #1;
    iv = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("abort_in_ready", ir, 1);
    chk("abort_out_valid", ov, 0);
    chk("abort_sum", s, 0);
    chk("abort_cout", co, 0);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    op4("after_abort", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0);

    op1("n1_nocin", 4'b1001, 4'b1110, 1'b0, 4'b0111, 1'b1);
    op1("n1_cin", 4'b1001, 4'b1110, 1'b1, 4'b1000, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
